// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic         unf;
  logic         inv;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, unf, inv
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf, unf, inv
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage floating-point multiplier, RNE rounding, flush-to-zero
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0]        BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0]         INF_MAG = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 s1_sign_q, s1_sign_d, s1_inv_q, s1_inv_d;
  logic                 s1_inf_q, s1_inf_d, s1_zero_q, s1_zero_d;
  logic signed [EW-1:0] s1_exp_q, s1_exp_d;
  logic [SW-1:0]        s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  logic                 s2_sign_q, s2_sign_d, s2_inv_q, s2_inv_d;
  logic                 s2_inf_q, s2_inf_d, s2_zero_q, s2_zero_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  logic [W-1:0]         result_q, result_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic                 adv;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                 msb, guard, sticky, inc, carry;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       frac_r;
  logic signed [EW-1:0] e_n;
  logic [W-1:0]         pack_res;
  logic                 pack_ovf, pack_unf, pack_inv;

  // The whole pipe moves in lockstep: it only freezes when a result is waiting.
  assign adv          = !out_valid_q | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.ovf       = ovf_q;
  assign io.unf       = unf_q;
  assign io.inv       = inv_q;

  always_comb begin
    ea     = io.a[W-2 -: EXP_W];
    eb     = io.b[W-2 -: EXP_W];
    fa     = io.a[MAN_W-1:0];
    fb     = io.b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
  end

  always_comb begin
    s1_valid_d = adv ? io.in_valid : s1_valid_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_inv_d   = s1_inv_q;
    s1_inf_d   = s1_inf_q;
    s1_zero_d  = s1_zero_q;
    s1_exp_d   = s1_exp_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s2_sign_d  = s2_sign_q;
    s2_inv_d   = s2_inv_q;
    s2_inf_d   = s2_inf_q;
    s2_zero_d  = s2_zero_q;
    s2_exp_d   = s2_exp_q;
    s2_prod_d  = s2_prod_q;
    if (adv) begin
      s1_sign_d = io.a[W-1] ^ io.b[W-1];
      s1_inv_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      s1_inf_d  = a_inf | b_inf;
      s1_zero_d = a_zero | b_zero;
      s1_exp_d  = signed'({2'b00, ea} + {2'b00, eb} - BIAS);
      s1_ma_d   = {1'b1, fa};
      s1_mb_d   = {1'b1, fb};
      s2_sign_d = s1_sign_q;
      s2_inv_d  = s1_inv_q;
      s2_inf_d  = s1_inf_q;
      s2_zero_d = s1_zero_q;
      s2_exp_d  = s1_exp_q;
      s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
    end
  end

  // Product lies in [1,4): the top bit picks which window becomes the fraction.
  always_comb begin
    msb    = s2_prod_q[PW-1];
    frac   = msb ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
    guard  = msb ? s2_prod_q[PW-2-MAN_W] : s2_prod_q[PW-3-MAN_W];
    sticky = msb ? (|s2_prod_q[PW-3-MAN_W:0]) : (|s2_prod_q[PW-4-MAN_W:0]);
    inc    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    carry  = frac_r[MAN_W];
    e_n    = s2_exp_q + EW'(msb) + EW'(carry);

    pack_res = {s2_sign_q, e_n[EXP_W-1:0], frac_r[MAN_W-1:0]};
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    pack_inv = 1'b0;
    if (s2_inv_q) begin
      pack_res = QNAN;
      pack_inv = 1'b1;
    end else if (s2_inf_q) begin
      pack_res = INF_MAG | {s2_sign_q, {(W-1){1'b0}}};
    end else if (s2_zero_q) begin
      pack_res = {s2_sign_q, {(W-1){1'b0}}};
    end else if (e_n >= EXP_MAX) begin
      pack_res = INF_MAG | {s2_sign_q, {(W-1){1'b0}}};
      pack_ovf = 1'b1;
    end else if (e_n[EW-1] || (e_n == '0)) begin
      pack_res = {s2_sign_q, {(W-1){1'b0}}};
      pack_unf = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = adv ? s2_valid_q : out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inv_d       = inv_q;
    if (adv && s2_valid_q) begin
      result_d = pack_res;
      ovf_d    = pack_ovf;
      unf_d    = pack_unf;
      inv_d    = pack_inv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_inv_q  <= s1_inv_d;
    s1_inf_q  <= s1_inf_d;
    s1_zero_q <= s1_zero_d;
    s1_exp_q  <= s1_exp_d;
    s1_ma_q   <= s1_ma_d;
    s1_mb_q   <= s1_mb_d;
    s2_sign_q <= s2_sign_d;
    s2_inv_q  <= s2_inv_d;
    s2_inf_q  <= s2_inf_d;
    s2_zero_q <= s2_zero_d;
    s2_exp_q  <= s2_exp_d;
    s2_prod_q <= s2_prod_d;
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard bench for fp_mul_pipe (binary32 and binary16 instances)
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .io(bus16));

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          drv;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;
  int stalled = 0;
  int n0;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OVF  = 3'b100;
  localparam logic [2:0] F_UNF  = 3'b010;
  localparam logic [2:0] F_INV  = 3'b001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Output side: compare every transferred result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output observed=0x%08h expected=none", bus.result);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("flags", {29'd0, bus.ovf, bus.unf, bus.inv}, {29'd0, e.flg});
        if (e.lat) check("latency", cyc - e.drv, 32'd3);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic [2:0] f, input bit lat);
    int n;
    n = 0;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("accept", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready) sb.push_back('{r, f, cyc, lat});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input logic [2:0] f);
    int n;
    n = 0;
    bus16.a = x;
    bus16.b = y;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("h_valid", {31'd0, bus16.out_valid}, 32'd1);
    check("h_result", {16'd0, bus16.result}, {16'd0, r});
    check("h_flags", {29'd0, bus16.ovf, bus16.unf, bus16.inv}, {29'd0, f});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.a = '0;
    bus16.b = '0;
    bus16.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {29'd0, bus.ovf, bus.unf, bus.inv}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(32'h40000000, 32'h40400000, 32'h40C00000, F_NONE, 1'b1);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE, 1'b1);
    send(32'h3F800001, 32'h3FFFFFFF, 32'h40000000, F_NONE, 1'b1);
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, F_NONE, 1'b1);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, F_OVF, 1'b1);
    send(32'h00800000, 32'h3F000000, 32'h00000000, F_UNF, 1'b1);
    send(32'h7F800000, 32'h80000000, 32'h7FC00000, F_INV, 1'b1);
    send(32'h80000000, 32'h40000000, 32'h80000000, F_NONE, 1'b1);
    drain();

    // Backpressure: three operands fill the pipe, then in_ready drops until release.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            stalled++;
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_result", bus.result, 32'h40000000);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join_none
    send(32'h3F800000, 32'h40000000, 32'h40000000, F_NONE, 1'b0);
    send(32'h40000000, 32'h40000000, 32'h40800000, F_NONE, 1'b0);
    send(32'hBF800000, 32'h40400000, 32'hC0400000, F_NONE, 1'b0);
    send(32'h3F000000, 32'h3F000000, 32'h3E800000, F_NONE, 1'b0);
    send(32'h40400000, 32'h40400000, 32'h41100000, F_NONE, 1'b0);
    send(32'h40000000, 32'h40400000, 32'h40C00000, F_NONE, 1'b0);
    drain();
    check("stall_cycles", stalled, 32'd2);
    check("bp_count", n_out - n0, 32'd6);

    // Reset with three operands in flight; none of them may surface afterwards.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(32'h40000000, 32'h40000000, 32'h40800000, F_NONE, 1'b0);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, F_NONE, 1'b0);
    send(32'h40400000, 32'h40000000, 32'h40C00000, F_NONE, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_result", bus.result, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    send(32'h40400000, 32'h40400000, 32'h41100000, F_NONE, 1'b1);
    drain();
    check("post_rst_count", n_out - n0, 32'd1);

    run16(16'h4000, 16'h4200, 16'h4600, F_NONE);
    run16(16'h7800, 16'h7800, 16'h7C00, F_OVF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
